// File: rtl/sample_frame_collector.sv
// sample_frame_collector: packs SAMPLES consecutive WIDTH-bit samples into a frame
// using two ping-pong banks, so one frame fills while the other awaits the consumer.
module sample_frame_collector #(
    parameter int SAMPLES = 4,
    parameter int WIDTH   = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sample,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic [WIDTH-1:0] frame [SAMPLES-1:0]
);

    localparam int IDX_W = $clog2(SAMPLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES - 1);

    logic [WIDTH-1:0] bank [0:1][0:SAMPLES-1];
    logic [1:0]       full;
    logic             wr_bank;
    logic             rd_bank;
    logic [IDX_W-1:0] wr_idx;

    logic accept;
    logic consume;

    // Handshake decode: write side blocks on a full write bank or a flush.
    always_comb begin
        in_ready    = !full[wr_bank] && !flush;
        frame_valid = full[rd_bank];
        accept      = in_valid && in_ready;
        consume     = frame_valid && frame_ready;
    end

    // Present the read bank directly as the output frame (register mux, no latency).
    always_comb begin
        for (int unsigned k = 0; k < SAMPLES; k++) begin
            frame[k] = bank[rd_bank][k];
        end
    end

    // Control state: write pointer, bank selects and full flags.
    // An accept only touches an empty bank and a consume only a full one,
    // so both full-flag updates in the same cycle never hit the same bit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_idx  <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            full    <= '0;
        end else begin
            if (flush) begin
                wr_idx <= '0;
            end else if (accept) begin
                if (wr_idx == LAST_IDX) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                    wr_idx        <= '0;
                end else begin
                    wr_idx <= wr_idx + IDX_W'(1);
                end
            end
            if (consume) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
        end
    end

    // Sample storage: cleared on reset, written on accept, never cleared on consume.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned k = 0; k < SAMPLES; k++) begin
                    bank[b][k] <= '0;
                end
            end
        end else if (accept) begin
            bank[wr_bank][wr_idx] <= in_sample;
        end
    end

endmodule

// File: tb/tb_sample_frame_collector.sv
// Testbench for sample_frame_collector: directed test-plan steps followed by a
// randomized phase, all compared against a queue-based frame model.
module tb_sample_frame_collector;

    localparam int SAMPLES = 4;
    localparam int WIDTH   = 3;
    localparam int FW      = SAMPLES * WIDTH;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_sample;
    logic             frame_valid;
    logic             frame_ready;
    logic [WIDTH-1:0] frame [SAMPLES-1:0];

    sample_frame_collector #(.SAMPLES(SAMPLES), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sample   (in_sample),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame       (frame)
    );

    always #5 clk = ~clk;

    // Reference model: completed frames waiting downstream (at most two) and
    // the samples collected so far towards the next frame.
    logic [FW-1:0]    fq [$];
    logic [WIDTH-1:0] part [$];
    bit               known    = 1'b0;
    bit               rst_flag = 1'b0;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input bit rst_n, input bit v, input logic [WIDTH-1:0] s,
                        input bit fr, input bit fl);
        logic [FW-1:0] got;
        logic [FW-1:0] packed_f;
        bit            m_ready;
        bit            acc;
        bit            cons;
        @(negedge clk);
        reset_n     = rst_n;
        in_valid    = v;
        in_sample   = s;
        frame_ready = fr;
        flush       = fl;
        #1;
        for (int k = 0; k < SAMPLES; k++) got[k*WIDTH +: WIDTH] = frame[k];
        m_ready = (fq.size() < 2) && !fl;
        if (known) begin
            chk("in_ready", 32'(in_ready), 32'(m_ready));
            chk("frame_valid", 32'(frame_valid), 32'(fq.size() > 0));
            if (fq.size() > 0) chk("frame", 32'(got), 32'(fq[0]));
            if (rst_flag) chk("frame_after_reset", 32'(got), 32'(0));
        end
        rst_flag = 1'b0;
        @(posedge clk);
        if (!rst_n) begin
            fq.delete();
            part.delete();
            known    = 1'b1;
            rst_flag = 1'b1;
        end else begin
            acc  = v && m_ready;
            cons = fr && (fq.size() > 0);
            if (cons) void'(fq.pop_front());
            if (fl) begin
                part.delete();
            end else if (acc) begin
                part.push_back(s);
                if (part.size() == SAMPLES) begin
                    for (int k = 0; k < SAMPLES; k++) packed_f[k*WIDTH +: WIDTH] = part[k];
                    fq.push_back(packed_f);
                    part.delete();
                end
            end
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] s, input bit fr);
        step(1'b1, 1'b1, s, fr, 1'b0);
    endtask

    task automatic idle(input bit fr);
        step(1'b1, 1'b0, '0, fr, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_sample = '0; frame_ready = 1'b0;

        // Reset, then one frame held for several cycles before a single consume.
        do_reset();
        idle(1'b0);
        push(3'd6, 1'b0); push(3'd2, 1'b0); push(3'd0, 1'b0); push(3'd7, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        // Back-pressure: eight samples fill both banks, ninth held until a consume.
        for (int i = 1; i <= 8; i++) push(3'(i), 1'b0);
        step(1'b1, 1'b1, 3'd5, 1'b0, 1'b0);
        step(1'b1, 1'b1, 3'd5, 1'b0, 1'b0);
        step(1'b1, 1'b1, 3'd5, 1'b1, 1'b0);
        push(3'd5, 1'b0);
        push(3'd1, 1'b0); push(3'd2, 1'b0); push(3'd3, 1'b0);
        idle(1'b1); idle(1'b1); idle(1'b0);

        // Full-rate streaming with the consumer always ready.
        for (int i = 0; i < 12; i++) push(3'($urandom), 1'b1);
        idle(1'b1); idle(1'b0);

        // Flush abandons the partial frame and refuses the sample offered with it.
        push(3'd3, 1'b0); push(3'd3, 1'b0);
        step(1'b1, 1'b1, 3'd6, 1'b0, 1'b1);
        push(3'd1, 1'b0); push(3'd3, 1'b0); push(3'd5, 1'b0); push(3'd7, 1'b0);
        idle(1'b0); idle(1'b1); idle(1'b0);

        // Reset with both banks full, then a fresh frame.
        for (int i = 0; i < 8; i++) push(3'($urandom), 1'b0);
        idle(1'b0);
        do_reset();
        idle(1'b0);
        for (int i = 0; i < 4; i++) push(3'($urandom), 1'b0);
        idle(1'b0); idle(1'b1); idle(1'b0);

        // Consume on the same edge that completes the other bank.
        for (int i = 0; i < 4; i++) push(3'($urandom), 1'b0);
        for (int i = 0; i < 3; i++) push(3'($urandom), 1'b0);
        push(3'($urandom), 1'b1);
        idle(1'b0); idle(1'b1); idle(1'b0);

        // Randomized traffic including occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 3) != 0),
                 3'($urandom),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 15) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
